// File: rtl/spi_flash_line_reader.sv
// rtl/spi_flash_line_reader.sv - CPU byte reads from SPI NOR flash through a one-line read buffer
//
// Purpose: serves bus byte reads from SPI NOR flash (mode 0, 0x03 or 0x0B
// with dummy clocks). The last fetched line is kept, so repeated reads within
// it complete without SPI traffic. Writes are acknowledged without side effects.
//
// Ports:
//   clk, reset        system clock, synchronous active-low reset
//   spi_ce            access in progress (from the address decoder)
//   i_ADDRESS_BUS     CPU byte address, latched at request start
//   i_RW              1 = read, 0 = write, latched with the address
//   i_invalidate      single-cycle pulse that drops the buffered line
//   i_SPI_MISO        flash serial data in
//   o_SPI_CLK/MOSI/CS flash pins (SCLK idles low, CS active low)
//   o_spi_data        read data, held until the next served read
//   o_MemoryReady     access complete, held while spi_ce stays high
module spi_flash_line_reader #(
   parameter int          ADDR_WIDTH   = 16,
   parameter int          LINE_BYTES   = 4,
   parameter int          CLK_DIV      = 1,
   parameter logic [23:0] BASE_OFFSET  = 24'h000000,
   parameter bit          FAST_READ    = 1'b0,
   parameter int          DUMMY_CYCLES = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spi_ce,
   input  logic [ADDR_WIDTH-1:0] i_ADDRESS_BUS,
   input  logic                  i_RW,
   input  logic                  i_invalidate,
   input  logic                  i_SPI_MISO,
   output logic                  o_SPI_CLK,
   output logic                  o_SPI_MOSI,
   output logic                  o_SPI_CS,
   output logic [7:0]            o_spi_data,
   output logic                  o_MemoryReady
);

   localparam int OFF_BITS = $clog2(LINE_BYTES);
   localparam int LINE_W   = LINE_BYTES * 8;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [7:0] CMD_BYTE = FAST_READ ? 8'h0B : 8'h03;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(LINE_BYTES - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CMD   = 3'd1;
   localparam logic [2:0] S_DUMMY = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_SERVE = 3'd5;

   logic [2:0]            state_q, state_d;
   logic [DIV_W-1:0]      div_q, div_d;
   logic [7:0]            bit_q, bit_d;
   logic [31:0]           tx_q, tx_d;
   logic [LINE_W-1:0]     line_q, line_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [ADDR_WIDTH-1:0] tag_q, tag_d;
   logic                  valid_q, valid_d;
   logic                  inv_q, inv_d;
   logic                  sclk_q, sclk_d;
   logic                  cs_q, cs_d;
   logic                  mosi_q, mosi_d;
   logic [7:0]            data_q, data_d;
   logic                  ready_q, ready_d;

   logic        tick;
   logic        hit_now;
   logic [23:0] flash_addr;
   logic [7:0]  last_bit;
   logic [2:0]  next_phase;

   // Line byte 0 is the first byte shifted in, so it sits in the top bits.
   function automatic logic [7:0] pick_byte(input logic [LINE_W-1:0] line,
                                            input logic [ADDR_WIDTH-1:0] a);
      logic [7:0] b;
      b = line[LINE_W-1 -: 8];
      for (int i = 0; i < LINE_BYTES; i++) begin
         if ((a & OFF_MASK) == ADDR_WIDTH'(i)) b = line[LINE_W-1-8*i -: 8];
      end
      return b;
   endfunction

   assign tick       = (div_q == DIV_W'(CLK_DIV - 1));
   assign hit_now    = valid_q && (tag_q == (i_ADDRESS_BUS >> OFF_BITS));
   assign flash_addr = 24'(i_ADDRESS_BUS & ~OFF_MASK) + BASE_OFFSET;

   always_comb begin
      last_bit   = 8'(LINE_W - 1);
      next_phase = S_DONE;
      case (state_q)
         S_CMD: begin
            last_bit   = 8'd31;
            next_phase = (FAST_READ && DUMMY_CYCLES > 0) ? S_DUMMY : S_DATA;
         end
         S_DUMMY: begin
            last_bit   = 8'(DUMMY_CYCLES - 1);
            next_phase = S_DATA;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      tx_d    = tx_q;
      line_d  = line_q;
      addr_d  = addr_q;
      tag_d   = tag_q;
      valid_d = valid_q;
      inv_d   = inv_q;
      sclk_d  = sclk_q;
      cs_d    = cs_q;
      mosi_d  = mosi_q;
      data_d  = data_q;
      ready_d = ready_q;
      case (state_q)
         S_IDLE: begin
            if (spi_ce) begin
               addr_d = i_ADDRESS_BUS;
               if (!i_RW) begin
                  state_d = S_SERVE;
               end else if (hit_now) begin
                  data_d  = pick_byte(line_q, i_ADDRESS_BUS);
                  state_d = S_SERVE;
               end else begin
                  // The line register doubles as the receive shifter, so it
                  // stops being a valid line the moment a fill starts.
                  state_d = S_CMD;
                  cs_d    = 1'b0;
                  mosi_d  = CMD_BYTE[7];
                  tx_d    = {CMD_BYTE[6:0], flash_addr, 1'b0};
                  div_d   = '0;
                  bit_d   = '0;
                  sclk_d  = 1'b0;
                  valid_d = 1'b0;
                  inv_d   = 1'b0;
               end
            end
         end
         S_CMD, S_DUMMY, S_DATA: begin
            if (!tick) begin
               div_d = div_q + DIV_W'(1);
            end else begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  if (state_q == S_DATA) line_d = {line_q[LINE_W-2:0], i_SPI_MISO};
               end else begin
                  // tx_q runs empty after the command/address, giving MOSI=0
                  // through the dummy and data phases.
                  sclk_d = 1'b0;
                  mosi_d = tx_q[31];
                  tx_d   = {tx_q[30:0], 1'b0};
                  bit_d  = bit_q + 8'd1;
                  if (bit_q == last_bit) begin
                     bit_d   = '0;
                     state_d = next_phase;
                  end
               end
            end
         end
         S_DONE: begin
            cs_d    = 1'b1;
            tag_d   = addr_q >> OFF_BITS;
            valid_d = !inv_q;
            data_d  = pick_byte(line_q, addr_q);
            state_d = S_SERVE;
         end
         S_SERVE: begin
            // Ready is always shown for at least one cycle, even if spi_ce
            // already fell during a fill.
            if (!ready_q) begin
               ready_d = 1'b1;
            end else if (!spi_ce) begin
               ready_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            cs_d    = 1'b1;
            sclk_d  = 1'b0;
            ready_d = 1'b0;
         end
      endcase
      // Invalidate wins over a fill completing in the same cycle; inv_q
      // remembers a pulse seen mid-fill.
      if (i_invalidate) begin
         valid_d = 1'b0;
         inv_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         tx_q    <= '0;
         line_q  <= '0;
         addr_q  <= '0;
         tag_q   <= '0;
         valid_q <= 1'b0;
         inv_q   <= 1'b0;
         sclk_q  <= 1'b0;
         cs_q    <= 1'b1;
         mosi_q  <= 1'b0;
         data_q  <= 8'h00;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
         line_q  <= line_d;
         addr_q  <= addr_d;
         tag_q   <= tag_d;
         valid_q <= valid_d;
         inv_q   <= inv_d;
         sclk_q  <= sclk_d;
         cs_q    <= cs_d;
         mosi_q  <= mosi_d;
         data_q  <= data_d;
         ready_q <= ready_d;
      end
   end

   assign o_SPI_CLK     = sclk_q;
   assign o_SPI_CS      = cs_q;
   assign o_SPI_MOSI    = mosi_q;
   assign o_spi_data    = data_q;
   assign o_MemoryReady = ready_q;

endmodule

// File: tb/tb_spi_flash_line_reader.sv
// tb/tb_spi_flash_line_reader.sv - scoreboard bench for spi_flash_line_reader
module tb_spi_flash_line_reader;

   typedef struct {
      int         inst;
      logic [7:0] data;
      int         lat;
      int         start;
      int         falls0;
      int         togs0;
      int         falls_exp;
      int         togs_exp;
      logic [39:0] hdr;
      int         period;
      int         width;
   } exp_t;

   exp_t sbq[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        resetn;
   logic [1:0]  ce, rw, inv;
   logic [15:0] addr0, addr1;
   wire  [1:0]  sclk, mosi, cs, rdy;
   logic [1:0]  miso;
   wire  [7:0]  dout0, dout1;
   logic        done;

   int checks = 0;
   int errors = 0;

   spi_flash_line_reader u0 (
      .clk(clk), .reset(resetn), .spi_ce(ce[0]), .i_ADDRESS_BUS(addr0),
      .i_RW(rw[0]), .i_invalidate(inv[0]), .i_SPI_MISO(miso[0]),
      .o_SPI_CLK(sclk[0]), .o_SPI_MOSI(mosi[0]), .o_SPI_CS(cs[0]),
      .o_spi_data(dout0), .o_MemoryReady(rdy[0])
   );

   spi_flash_line_reader #(
      .CLK_DIV(2), .BASE_OFFSET(24'h010000), .FAST_READ(1'b1), .DUMMY_CYCLES(8)
   ) u1 (
      .clk(clk), .reset(resetn), .spi_ce(ce[1]), .i_ADDRESS_BUS(addr1),
      .i_RW(rw[1]), .i_invalidate(inv[1]), .i_SPI_MISO(miso[1]),
      .o_SPI_CLK(sclk[1]), .o_SPI_MOSI(mosi[1]), .o_SPI_CS(cs[1]),
      .o_spi_data(dout1), .o_MemoryReady(rdy[1])
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic rst_s = 1'b1;
   always @(posedge clk) rst_s <= resetn;

   function automatic int hdr_len(input int g);
      return (g == 0) ? 32 : 40;
   endfunction

   // Flash model bookkeeping: counts SCLK rises inside a CS window, captures
   // the MOSI header and rise-to-rise spacing, and serves one fixed line.
   int          rises [2];
   int          togs  [2];
   int          falls [2];
   int          pmin  [2];
   int          pmax  [2];
   int          lastr [2];
   logic [39:0] hdr_bits [2];
   logic [31:0] fword [2];

   initial begin : flash
      logic [1:0] cs_p, sclk_p;
      int d;
      fword[0] = 32'hFA112233;
      fword[1] = 32'hA1B2C3D4;
      for (int g = 0; g < 2; g++) begin
         rises[g] = 0; togs[g] = 0; falls[g] = 0; pmin[g] = 1000000;
         pmax[g] = 0; lastr[g] = 0; hdr_bits[g] = '0;
      end
      cs_p = 2'b11;
      sclk_p = 2'b00;
      forever begin
         @(negedge clk);
         for (int g = 0; g < 2; g++) begin
            if (cs_p[g] && !cs[g]) begin
               rises[g] = 0; hdr_bits[g] = '0; falls[g]++;
               pmin[g] = 1000000; pmax[g] = 0;
            end
            if (sclk[g] !== sclk_p[g]) togs[g]++;
            if (sclk[g] && !sclk_p[g] && !cs[g]) begin
               if (rises[g] < hdr_len(g)) hdr_bits[g] = {hdr_bits[g][38:0], mosi[g]};
               if (rises[g] > 0) begin
                  d = cyc - lastr[g];
                  if (d < pmin[g]) pmin[g] = d;
                  if (d > pmax[g]) pmax[g] = d;
               end
               lastr[g] = cyc;
               rises[g]++;
            end
         end
         cs_p = cs;
         sclk_p = sclk;
      end
   end

   always_comb begin
      int j;
      j = 0;
      miso = 2'b00;
      for (int g = 0; g < 2; g++) begin
         j = rises[g] - hdr_len(g);
         if (j >= 0 && j < 32) miso[g] = fword[g][31-j];
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic summary();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   endtask

   // Monitor: the only process that compares.
   initial begin : monitor
      exp_t e;
      int want_w, hi_cnt;
      logic [1:0] rdy_p;
      logic [7:0] dv;
      want_w = 0; hi_cnt = 0; rdy_p = 2'b00;
      forever begin
         @(negedge clk);
         if (!rst_s) begin
            for (int g = 0; g < 2; g++) begin
               chk("reset_cs", cs[g], 1'b1);
               chk("reset_sclk", sclk[g], 1'b0);
               chk("reset_mosi", mosi[g], 1'b0);
               chk("reset_data", (g == 0) ? dout0 : dout1, 8'h00);
               chk("reset_ready", rdy[g], 1'b0);
            end
         end
         for (int g = 0; g < 2; g++) begin
            dv = (g == 0) ? dout0 : dout1;
            if (rdy[g] && !rdy_p[g]) begin
               if (sbq.size() == 0) begin
                  chk("unexpected_ready", rdy[g], 1'b0);
               end else begin
                  e = sbq.pop_front();
                  chk("ready_instance", g, e.inst);
                  chk("read_data", dv, e.data);
                  chk("latency", cyc - e.start + 1, e.lat);
                  chk("cs_falls", falls[g] - e.falls0, e.falls_exp);
                  chk("sclk_toggles", togs[g] - e.togs0, e.togs_exp);
                  if (e.falls_exp != 0) chk("mosi_header", hdr_bits[g], e.hdr);
                  if (e.period != 0) begin
                     chk("sclk_period_min", pmin[g], e.period);
                     chk("sclk_period_max", pmax[g], e.period);
                  end
                  want_w = e.width;
                  hi_cnt = 1;
               end
            end else if (rdy[g]) begin
               hi_cnt++;
            end
            if (!rdy[g] && rdy_p[g] && want_w != 0) begin
               chk("ready_width", hi_cnt, want_w);
               want_w = 0;
            end
         end
         rdy_p = rdy;
         if (sbq.size() != 0 && cyc - sbq[0].start > sbq[0].lat + 40) begin
            chk("ready_timeout", cyc - sbq[0].start + 1, sbq[0].lat);
            void'(sbq.pop_front());
         end
         if (done) begin
            chk("queue_empty", sbq.size(), 0);
            summary();
         end
         if (cyc > 20000) begin
            chk("watchdog_cycles", cyc, 20000);
            summary();
         end
      end
   end

   task automatic req(input int g, input logic [15:0] a, input logic r,
                      input logic [7:0] d, input int lat, input int miss,
                      input int tg, input logic [39:0] h, input int per,
                      input bit drop);
      exp_t e;
      @(negedge clk);
      e.inst = g; e.data = d; e.lat = lat; e.start = cyc + 1;
      e.falls0 = falls[g]; e.togs0 = togs[g]; e.falls_exp = miss;
      e.togs_exp = tg; e.hdr = h; e.period = per; e.width = drop ? 1 : 0;
      sbq.push_back(e);
      if (g == 0) addr0 = a; else addr1 = a;
      rw[g] = r;
      ce[g] = 1'b1;
      if (drop) begin
         repeat (3) @(negedge clk);
         ce[g] = 1'b0;
      end
      for (int k = 0; k < 600 && !rdy[g]; k++) @(negedge clk);
      repeat (2) @(negedge clk);
      ce[g] = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin : driver
      resetn = 1'b0; ce = 2'b00; rw = 2'b00; inv = 2'b00;
      addr0 = '0; addr1 = '0; done = 1'b0;
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
      // Default instance: cold miss, hit, write, invalidate-then-miss.
      req(0, 16'h3AAA, 1'b1, 8'h22, 131, 1, 128, 40'h0003003AA8, 2, 1'b0);
      req(0, 16'h3AA9, 1'b1, 8'h11, 2, 0, 0, 40'h0, 0, 1'b0);
      req(0, 16'h3AA8, 1'b0, 8'h11, 2, 0, 0, 40'h0, 0, 1'b0);
      @(negedge clk); inv[0] = 1'b1;
      @(negedge clk); inv[0] = 1'b0;
      req(0, 16'h3AAA, 1'b1, 8'h22, 131, 1, 128, 40'h0003003AA8, 2, 1'b0);
      // Reset in the middle of the data phase, then the line must be refetched.
      @(negedge clk); addr0 = 16'h3AAA; rw[0] = 1'b1; ce[0] = 1'b1;
      for (int k = 0; k < 2000 && rises[0] < 40; k++) @(negedge clk);
      resetn = 1'b0; ce[0] = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (2) @(negedge clk);
      req(0, 16'h3AAA, 1'b1, 8'h22, 131, 1, 128, 40'h0003003AA8, 2, 1'b0);
      // Fast-read instance: miss with dummy clocks, hit, and early spi_ce drop.
      req(1, 16'h0004, 1'b1, 8'hA1, 291, 1, 144, 40'h0B01000400, 4, 1'b0);
      req(1, 16'h0007, 1'b1, 8'hD4, 2, 0, 0, 40'h0, 0, 1'b0);
      req(1, 16'h0008, 1'b1, 8'hA1, 291, 1, 144, 40'h0B01000800, 4, 1'b1);
      repeat (4) @(negedge clk);
      done = 1'b1;
   end

endmodule

// File: doc/spi_flash_line_reader.md
# spi_flash_line_reader

Parametrised successor to `spi_flash_controller` in the CPU memory path. It serves byte reads from the CPU bus out of SPI NOR flash, with these additions:
- configurable bus width, flash base offset and SCLK divider;
- optional FAST_READ (0x0B) with dummy cycles;
- a one-line read buffer, so repeated accesses within the same line are served without SPI traffic.

It sits between the bus address decoder (which drives `spi_ce`) and the external flash pins.

## Interface
- `ADDR_WIDTH`, 16: CPU address bus width.
- `LINE_BYTES`, 4: bytes fetched per miss. Power of two, 1..16.
- `CLK_DIV`, 1: `clk` cycles per SCLK half-period. Must be ≥1.
- `BASE_OFFSET`, 24'h000000: added to the line-aligned CPU address to form the 24-bit flash address. Carry out of bit 23 is discarded.
- `FAST_READ`, 0: 0 selects command 0x03; 1 selects 0x0B plus `DUMMY_CYCLES` dummy SCLKs.
- `DUMMY_CYCLES`, 8: dummy SCLK count in fast mode.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-low reset.
- `spi_ce` in 1: chip enable from the address decoder. High = access in progress.
- `i_ADDRESS_BUS` in ADDR_WIDTH: CPU address, sampled at request start.
- `i_RW` in 1: 1 = read, 0 = write. Sampled with the address.
- `i_invalidate` in 1: single-cycle pulse that clears the line buffer valid bit.
- `i_SPI_MISO` in 1: flash serial data out.
- `o_SPI_CLK` out 1: SCLK, mode 0, idles low.
- `o_SPI_MOSI` out 1: command/address bits, MSB first.
- `o_SPI_CS` out 1: active-low flash select.
- `o_spi_data` out 8: read data. Held until the next served read.
- `o_MemoryReady` out 1: access complete.

## Operation
- Request start: the state is IDLE and `spi_ce`=1. Address and `i_RW` are latched on that edge. A new request requires `spi_ce` to have been 0 for at least 1 cycle.
- Write request (`i_RW`=0): go to SERVE immediately. There is no SPI activity and `o_spi_data` is unchanged.
- Read hit: line valid AND tag == `addr[ADDR_WIDTH-1:log2(LINE_BYTES)]`.
  - Go to SERVE.
  - Load `o_spi_data` with `line[addr offset]`.
- Read miss, SPI transfer:
  - CMD: CS low. Shift 8 command bits, then 24 address bits = `BASE_OFFSET` + (addr with offset bits zeroed).
  - DUMMY: only when `FAST_READ`=1. Run `DUMMY_CYCLES` SCLKs with MOSI=0.
  - DATA: shift in `LINE_BYTES`×8 bits, MSB first. The first byte is stored at line[0].
- Read miss, completion:
  - DONE: CS high; set tag and valid.
  - Load `o_spi_data` from the requested offset, then go to SERVE.
- SERVE: `o_MemoryReady`=1. Hold it while `spi_ce`=1. When `spi_ce`=0 is sampled, drop ready and return to IDLE.
- States: IDLE, CMD, DUMMY, DATA, DONE, SERVE. Any unused encoding returns to IDLE.
- SPI mode 0:
  - MOSI changes `clk` edges at SCLK falling points; before the first rise it is set while CS falls.
  - MISO is sampled at the `clk` edge that raises SCLK.
  - Bit counter width is 8 bits.
- `i_invalidate`:
  - Clears valid on the next edge from any state.
  - If it is asserted during CMD/DUMMY/DATA, the in-flight fill still serves its own request, but valid stays 0 afterward.
  - If it coincides with DONE, invalidate wins.
- `spi_ce` dropping before SERVE does not abort a fill. The fill completes, and SERVE then sees `spi_ce`=0 and returns to IDLE after 1 cycle with ready pulsed for 1 cycle.

## Timing
- Reset value (`reset`=0 at an edge) of each output:
  - `o_SPI_CS`=1, `o_SPI_CLK`=0, `o_SPI_MOSI`=0;
  - `o_spi_data`=8'h00, `o_MemoryReady`=0.
- Reset also clears valid, returns the state to IDLE, and aborts any transfer mid-bit.
- Hit or write latency: `o_MemoryReady` rises 2 edges after the edge that samples `spi_ce`=1 (start edge → SERVE edge → visible).
- Miss latency, where B = 32 + (FAST_READ ? DUMMY_CYCLES : 0) + 8×LINE_BYTES:
  - edges from start to ready = 1 (CS setup) + 2×CLK_DIV×B + 1 (DONE) + 1 (SERVE);
  - defaults give 131.
- CS high time between transactions is ≥2 `clk` cycles. This is guaranteed by DONE plus SERVE.
- `o_MemoryReady` falls on the edge after `spi_ce`=0 is sampled.

## Test plan
- Defaults, read 0x3AAA (cold):
  - MOSI shows 0x03, 0x00, 0x3A, 0xA8.
  - With MISO bytes 0xFA, 0x11, 0x22, 0x33, `o_spi_data`=0x22 and ready at cycle 131. CS is low for exactly 128 SCLK half-periods.
- Then read 0x3AA9: `o_spi_data`=0x11, ready after 2 edges, CS stays high throughout.
- Write to 0x3AA8 (`i_RW`=0): ready after 2 edges, no SCLK toggles, `o_spi_data` still 0x11.
- `FAST_READ`=1, `BASE_OFFSET`=24'h010000, `CLK_DIV`=2, read 0x0004:
  - MOSI shows 0x0B, 0x01, 0x00, 0x04, then 8 dummy SCLKs.
  - SCLK period is 4 `clk` cycles.
  - Ready at 1 + 4×72 + 2 = 291.
- Pulse `i_invalidate`, then re-read 0x3AAA: a full SPI fetch recurs (cache miss).
- Assert `reset`=0 mid-DATA:
  - next edge: CS=1, SCLK=0, ready=0;
  - a following read of 0x3AAA is a miss.
